// File: rtl/fir_sat_pkg.sv
// Shared types and constants for the FIR variable-saturation range controller.
// Holds the controller state encoding and the default output-field geometry.
package fir_sat_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    SETTLE  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_MAX = 2'd3;
  localparam int         NUM_SEL = 4;

  localparam int OUT_WIDTH_DEFAULT = 12;
  localparam int LSB_BASE_DEFAULT  = 15;

endpackage

// File: rtl/fir_sat_range_ctrl_if.sv
// Avalon-ST style sink tap carrying the full-precision FIR output stream.
// The controller only observes the stream, so it has no ready signal.
interface fir_sat_range_ctrl_if #(
  parameter int IN_WIDTH = 35
);

  logic [IN_WIDTH-1:0] ast_sink_data;
  logic                ast_sink_valid;
  logic [1:0]          ast_sink_error;

  modport master (
    output ast_sink_data,
    output ast_sink_valid,
    output ast_sink_error
  );

  modport slave (
    input ast_sink_data,
    input ast_sink_valid,
    input ast_sink_error
  );

endinterface

// File: rtl/fir_sat_range_classify.sv
// Combinational sample classifier: does the sample clip at the current window
// select, and would it still fit one window lower.
module fir_sat_range_classify
  import fir_sat_pkg::*;
#(
  parameter int IN_WIDTH  = 35,
  parameter int OUT_WIDTH = OUT_WIDTH_DEFAULT,
  parameter int LSB_BASE  = LSB_BASE_DEFAULT
) (
  input  logic [IN_WIDTH-1:0] data,
  input  logic [1:0]          sel,
  output logic                sat,
  output logic                fit
);

  logic [NUM_SEL-1:0] fits_at;

  // A sample fits window s when everything from the field MSB upward is a
  // pure sign extension, i.e. an arithmetic shift leaves only 0 or -1.
  for (genvar s = 0; s < NUM_SEL; s++) begin : g_sel
    localparam int TOP = LSB_BASE + s + OUT_WIDTH - 1;
    logic signed [IN_WIDTH-1:0] upper;
    assign upper      = $signed(data) >>> TOP;
    assign fits_at[s] = (upper == '0) || (upper == '1);
  end

  assign sat = !fits_at[sel];
  // The sel-1 index wraps at sel=0, but the guard masks that case out.
  assign fit = (sel != 2'd0) && fits_at[sel - 2'd1];

endmodule

// File: rtl/fir_sat_range_ctrl.sv
// Automatic range controller: counts clipping / spare-headroom samples per
// measurement window and steps the 2-bit window select once per window.
module fir_sat_range_ctrl
  import fir_sat_pkg::*;
#(
  parameter int IN_WIDTH    = 35,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEFAULT,
  parameter int LSB_BASE    = LSB_BASE_DEFAULT,
  parameter int WINDOW_LOG2 = 10,
  parameter int SAT_THRESH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   auto_en,
  input  logic [1:0]             manual_sel,
  fir_sat_range_ctrl_if.slave    sink,
  output logic [1:0]             sel_o,
  output logic                   sel_change_o,
  output logic [WINDOW_LOG2:0]   last_sat_cnt_o,
  output logic [WINDOW_LOG2:0]   last_fit_cnt_o
);

  typedef logic [WINDOW_LOG2-1:0] sample_cnt_t;
  typedef logic [WINDOW_LOG2:0]   stat_cnt_t;

  localparam sample_cnt_t SAMPLE_ONE  = sample_cnt_t'(1);
  localparam sample_cnt_t SAMPLE_LAST = '1;
  localparam stat_cnt_t   STAT_ONE    = stat_cnt_t'(1);
  localparam stat_cnt_t   STAT_MAX    = '1;
  localparam stat_cnt_t   WINDOW_LEN  = stat_cnt_t'(2 ** WINDOW_LOG2);
  localparam stat_cnt_t   SAT_LIMIT   = stat_cnt_t'(SAT_THRESH);

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, deassertion is aligned to clk.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int;

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        sel_change_q, sel_change_d;
  sample_cnt_t sample_cnt_q, sample_cnt_d;
  stat_cnt_t   sat_cnt_q, sat_cnt_d;
  stat_cnt_t   fit_cnt_q, fit_cnt_d;
  stat_cnt_t   last_sat_q, last_sat_d;
  stat_cnt_t   last_fit_q, last_fit_d;

  logic        sample_sat;
  logic        sample_fit;
  logic        counted;
  logic        window_last;
  stat_cnt_t   sat_sum;
  stat_cnt_t   fit_sum;

  fir_sat_range_classify #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .LSB_BASE  (LSB_BASE)
  ) u_classify (
    .data (sink.ast_sink_data),
    .sel  (sel_q),
    .sat  (sample_sat),
    .fit  (sample_fit)
  );

  assign counted     = sink.ast_sink_valid && (sink.ast_sink_error == 2'b00);
  assign window_last = counted && (sample_cnt_q == SAMPLE_LAST);

  // Window totals including the current sample, saturating at the counter max.
  assign sat_sum = (sample_sat && (sat_cnt_q != STAT_MAX)) ? sat_cnt_q + STAT_ONE : sat_cnt_q;
  assign fit_sum = (sample_fit && (fit_cnt_q != STAT_MAX)) ? fit_cnt_q + STAT_ONE : fit_cnt_q;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q      <= IDLE;
      sel_q        <= SEL_MAX;
      sel_change_q <= 1'b0;
      sample_cnt_q <= '0;
      sat_cnt_q    <= '0;
      fit_cnt_q    <= '0;
      last_sat_q   <= '0;
      last_fit_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_change_q <= sel_change_d;
      sample_cnt_q <= sample_cnt_d;
      sat_cnt_q    <= sat_cnt_d;
      fit_cnt_q    <= fit_cnt_d;
      last_sat_q   <= last_sat_d;
      last_fit_q   <= last_fit_d;
    end
  end

  // NOTE: every variable gets a hold default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sample_cnt_d = sample_cnt_q;
    sat_cnt_d    = sat_cnt_q;
    fit_cnt_d    = fit_cnt_q;
    last_sat_d   = last_sat_q;
    last_fit_d   = last_fit_q;

    if (!auto_en) begin
      // Manual mode from any state; a partial window is thrown away.
      state_d      = IDLE;
      sel_d        = manual_sel;
      sample_cnt_d = '0;
      sat_cnt_d    = '0;
      fit_cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = MEASURE;
        end

        MEASURE, SETTLE: begin
          if (counted) begin
            sample_cnt_d = sample_cnt_q + SAMPLE_ONE;
            sat_cnt_d    = sat_sum;
            fit_cnt_d    = fit_sum;
            if (window_last) begin
              last_sat_d   = sat_sum;
              last_fit_d   = fit_sum;
              sample_cnt_d = '0;
              sat_cnt_d    = '0;
              fit_cnt_d    = '0;
              state_d      = MEASURE;
              // A settle window only lets the datapath output stabilise.
              if (state_q == MEASURE) begin
                if ((sat_sum >= SAT_LIMIT) && (sel_q < SEL_MAX)) begin
                  sel_d   = sel_q + 2'd1;
                  state_d = SETTLE;
                end else if ((fit_sum == WINDOW_LEN) && (sel_q > 2'd0)) begin
                  sel_d   = sel_q - 2'd1;
                  state_d = SETTLE;
                end
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    sel_change_d = (sel_d != sel_q);
  end

  assign sel_o          = sel_q;
  assign sel_change_o   = sel_change_q;
  assign last_sat_cnt_o = last_sat_q;
  assign last_fit_cnt_o = last_fit_q;

endmodule

// File: tb/tb_fir_sat_range_ctrl.sv
// Self-checking bench for fir_sat_range_ctrl: directed range scenarios plus
// randomized traffic, all compared against a sample-level reference model.
module tb_fir_sat_range_ctrl;

  localparam int IN_W   = 35;
  localparam int WLOG2  = 4;
  localparam int WIN    = 16;
  localparam int THRESH = 4;

  localparam logic [IN_W-1:0] D_SMALL = 35'd100;
  localparam logic [IN_W-1:0] D_BIG   = 35'd134217728;  // 2**27

  logic               clk;
  logic               reset;
  logic               auto_en;
  logic [1:0]         manual_sel;
  logic [1:0]         sel_o;
  logic               sel_change_o;
  logic [WLOG2:0]     last_sat_cnt_o;
  logic [WLOG2:0]     last_fit_cnt_o;

  fir_sat_range_ctrl_if #(.IN_WIDTH(IN_W)) sink_if ();

  fir_sat_range_ctrl #(
    .IN_WIDTH    (IN_W),
    .WINDOW_LOG2 (WLOG2),
    .SAT_THRESH  (THRESH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .auto_en        (auto_en),
    .manual_sel     (manual_sel),
    .sink           (sink_if),
    .sel_o          (sel_o),
    .sel_change_o   (sel_change_o),
    .last_sat_cnt_o (last_sat_cnt_o),
    .last_fit_cnt_o (last_fit_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks the window as a sample tally, with clipping decided
  // by the numeric range each output window can represent.
  // ---------------------------------------------------------------------------
  int m_mode;       // 0 manual, 1 measuring, 2 settling
  int m_sel;
  int m_n, m_sat, m_fit;
  int m_last_sat, m_last_fit;
  int m_change;

  function automatic bit in_range(input logic [IN_W-1:0] d, input int s);
    longint v, lim;
    v   = longint'($signed(d));
    lim = longint'(1) << (15 + s + 12 - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  function automatic int is_sat(input logic [IN_W-1:0] d, input int s);
    return in_range(d, s) ? 0 : 1;
  endfunction

  function automatic int fits_lower(input logic [IN_W-1:0] d, input int s);
    return (s > 0 && in_range(d, s - 1)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 3; m_n = 0; m_sat = 0; m_fit = 0;
    m_last_sat = 0; m_last_fit = 0; m_change = 0;
  endtask

  task automatic model_clock(input bit ae, input logic [1:0] ms, input logic [IN_W-1:0] d,
                             input bit v, input logic [1:0] e);
    int old_sel;
    old_sel = m_sel;
    if (!ae) begin
      m_mode = 0; m_sel = int'(ms); m_n = 0; m_sat = 0; m_fit = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (v && e == 2'b00) begin
      m_sat += is_sat(d, m_sel);
      m_fit += fits_lower(d, m_sel);
      m_n++;
      if (m_n == WIN) begin
        m_last_sat = m_sat;
        m_last_fit = m_fit;
        if (m_mode == 1 && m_sat >= THRESH && m_sel < 3) begin
          m_sel++; m_mode = 2;
        end else if (m_mode == 1 && m_fit == WIN && m_sel > 0) begin
          m_sel--; m_mode = 2;
        end else begin
          m_mode = 1;
        end
        m_n = 0; m_sat = 0; m_fit = 0;
      end
    end
    m_change = (m_sel != old_sel) ? 1 : 0;
  endtask

  // One cycle: drive after the falling edge, clock, then compare on the next
  // falling edge.
  task automatic step(input bit ae, input logic [1:0] ms, input logic [IN_W-1:0] d,
                      input bit v, input logic [1:0] e);
    auto_en                = ae;
    manual_sel             = ms;
    sink_if.ast_sink_data  = d;
    sink_if.ast_sink_valid = v;
    sink_if.ast_sink_error = e;
    @(posedge clk);
    model_clock(ae, ms, d, v, e);
    @(negedge clk);
    check("sel_o",      64'(sel_o),          64'(m_sel));
    check("sel_change", 64'(sel_change_o),   64'(m_change));
    check("last_sat",   64'(last_sat_cnt_o), 64'(m_last_sat));
    check("last_fit",   64'(last_fit_cnt_o), 64'(m_last_fit));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset                  = 1'b1;
    auto_en                = 1'b0;
    manual_sel             = 2'd3;
    sink_if.ast_sink_valid = 1'b0;
    sink_if.ast_sink_error = 2'b00;
    sink_if.ast_sink_data  = '0;
    #1;
    check({tag, "_sel"},      64'(sel_o),          64'd3);
    check({tag, "_change"},   64'(sel_change_o),   64'd0);
    check({tag, "_last_sat"}, 64'(last_sat_cnt_o), 64'd0);
    check({tag, "_last_fit"}, 64'(last_fit_cnt_o), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic samples(input int n, input logic [IN_W-1:0] d, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 2'd0, d, 1'b1, 2'b00);
      if (sel_change_o) pulses++;
    end
  endtask

  function automatic logic [IN_W-1:0] rand_data(input int profile);
    logic [63:0] wide;
    longint      b;
    int          pick;
    pick = (profile == 0) ? $urandom_range(0, 2) :
           (profile == 1) ? $urandom_range(2, 4) : $urandom_range(0, 4);
    case (pick)
      0: wide = 64'($urandom_range(0, 1 << 20));
      1: wide = 64'(-longint'($urandom_range(0, 1 << 22)));
      2: begin
        b    = longint'(1) << (26 + $urandom_range(0, 3));
        b    = b - longint'($urandom_range(0, 1));
        wide = ($urandom_range(0, 1) == 1) ? 64'(b) : 64'(-b - 1 + longint'($urandom_range(0, 2)));
      end
      3: wide = 64'(D_BIG);
      default: wide = {$urandom, $urandom};
    endcase
    return wide[IN_W-1:0];
  endfunction

  int pulses;

  initial begin
    reset                  = 1'b0;
    auto_en                = 1'b0;
    manual_sel             = 2'd3;
    sink_if.ast_sink_data  = '0;
    sink_if.ast_sink_valid = 1'b0;
    sink_if.ast_sink_error = 2'b00;
    model_reset();
    #1 reset = 1'b1;
    #2;
    check("por_sel",    64'(sel_o),          64'd3);
    check("por_change", 64'(sel_change_o),   64'd0);
    check("por_sat",    64'(last_sat_cnt_o), 64'd0);
    check("por_fit",    64'(last_fit_cnt_o), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Range down: 3 -> 2 -> 1 -> 0, then a settle window holding at 0.
    step(1'b1, 2'd3, D_SMALL, 1'b1, 2'b00);
    samples(96, D_SMALL, pulses);
    check("down_pulses", 64'(pulses), 64'd3);
    check("down_sel",    64'(sel_o),  64'd0);

    // Range up at sel 0: four clipping samples close the window upward.
    for (int i = 0; i < WIN; i++) step(1'b1, 2'd0, (i < 4) ? D_BIG : D_SMALL, 1'b1, 2'b00);
    check("up_sel",  64'(sel_o),          64'd1);
    check("up_sat4", 64'(last_sat_cnt_o), 64'd4);

    // Back to 0 through manual mode, then three clippers are not enough.
    step(1'b0, 2'd0, D_SMALL, 1'b0, 2'b00);
    step(1'b1, 2'd0, D_SMALL, 1'b0, 2'b00);
    for (int i = 0; i < WIN; i++) step(1'b1, 2'd0, (i < 3) ? D_BIG : D_SMALL, 1'b1, 2'b00);
    check("up3_sel", 64'(sel_o),          64'd0);
    check("up3_sat", 64'(last_sat_cnt_o), 64'd3);

    // Errored samples never count toward a window.
    for (int i = 0; i < WIN; i++) step(1'b1, 2'd0, D_BIG, 1'b1, 2'b01);
    check("err_sat_hold", 64'(last_sat_cnt_o), 64'd3);
    samples(WIN, D_SMALL, pulses);
    check("err_close_sat", 64'(last_sat_cnt_o), 64'd0);
    check("err_sel",       64'(sel_o),          64'd0);

    // Manual select, then an aborted partial window.
    step(1'b0, 2'd2, D_SMALL, 1'b1, 2'b00);
    check("man_sel",   64'(sel_o),        64'd2);
    check("man_pulse", 64'(sel_change_o), 64'd1);
    step(1'b1, 2'd2, D_SMALL, 1'b1, 2'b00);
    samples(10, D_SMALL, pulses);
    step(1'b0, 2'd2, D_SMALL, 1'b1, 2'b00);
    step(1'b1, 2'd2, D_SMALL, 1'b1, 2'b00);
    samples(15, D_SMALL, pulses);
    check("abort_hold", 64'(sel_o), 64'd2);
    samples(1, D_SMALL, pulses);
    check("abort_step", 64'(sel_o), 64'd1);

    // Settle window ignores clipping; the following measure window reacts.
    samples(WIN, D_BIG, pulses);
    check("settle_pulses", 64'(pulses), 64'd0);
    check("settle_sel",    64'(sel_o),  64'd1);
    samples(WIN, D_BIG, pulses);
    check("settle_after", 64'(sel_o), 64'd2);

    // Reset in the middle of traffic.
    samples(7, D_SMALL, pulses);
    do_reset("mid_rst");

    // Randomized traffic in blocks of varying amplitude profile.
    for (int blk = 0; blk < 20; blk++) begin
      int profile;
      profile = $urandom_range(0, 2);
      for (int i = 0; i < 150; i++) begin
        bit         ae, v;
        logic [1:0] e;
        ae = ($urandom_range(0, 199) != 0);
        v  = ($urandom_range(0, 4) != 0);
        e  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        step(ae, 2'($urandom_range(0, 3)), rand_data(profile), v, e);
      end
    end

    do_reset("end_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
